// File: rtl/console_pkg.sv
// Shared constants for the character console devices: register offsets,
// status/control bit positions and the RX_DATA word format.
package console_pkg;

   localparam logic [7:0] RX_DATA_ADDR   = 8'h00;
   localparam logic [7:0] RX_STATUS_ADDR = 8'h04;
   localparam logic [7:0] RX_CTRL_ADDR   = 8'h0C;

   // Output-side offset; it shares 0x04 with RX_STATUS and is told apart
   // only by the device base address.
   localparam logic [7:0] CHAR_OUT_ADDR  = 8'h04;

   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVERFLOW  = 2;
   localparam int ST_COUNT_LSB = 8;

   localparam int CTRL_IRQ_EN  = 0;
   localparam int CTRL_CLR_OVF = 1;
   localparam int CTRL_FLUSH   = 2;

   function automatic logic [31:0] rx_data_word(input logic valid, input logic [7:0] ch);
      return {valid, 23'b0, ch};
   endfunction

endpackage

// File: rtl/console_rx_if.sv
// Bus and host-byte signals of the console receive device.
// Handshake: a read is req_i & ~we_i in cycle N; the device answers with a
// one-cycle rvalid_o pulse and rdata_o in N+1. Writes get no response. The
// host strobe rx_valid_i carries one byte per asserted cycle, no backpressure.
interface console_rx_if;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        rvalid_o;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;

   modport master (
      output req_i, we_i, addr_i, wdata_i, rx_valid_i, rx_data_i,
      input  rdata_o, rvalid_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, rx_valid_i, rx_data_i,
      output rdata_o, rvalid_o
   );
endinterface

// File: rtl/console_rx_fifo.sv
// Byte FIFO with flush; a push into a full FIFO is accepted when a pop
// frees the head slot in the same cycle. Storage is never reset.
module console_rx_fifo #(
   parameter int Depth = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [7:0]             wr_data,
   output logic [7:0]             rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(Depth):0] count
);
   localparam int AW = $clog2(Depth);

   logic [7:0]    mem [Depth];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (AW+1)'(Depth));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty & ~flush;
   assign push_ok = push & ~flush & (~full | pop_ok);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because Depth is a power of two.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/console_rx.sv
// Console receive device: host bytes are queued in a FIFO and read by the
// CPU over the memory-mapped bus, with status, sticky overflow and irq.
module console_rx
   import console_pkg::*;
#(
   parameter int Depth        = 16,
   parameter bit IrqDefaultEn = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   console_rx_if.slave bus,
   output logic       irq_o
);
   localparam int CW = $clog2(Depth) + 1;

   logic [7:0]    offset;
   logic          rd_req;
   logic          ctrl_wr;
   logic          pop_ok;
   logic          flush;
   logic          clr_ovf;
   logic          ovf_set;
   logic          overflow;
   logic          irq_en;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [7:0]    count8;
   logic [7:0]    head;
   logic [31:0]   rd_mux;
   logic          unused_bits;

   assign offset  = bus.addr_i[7:0];
   assign rd_req  = bus.req_i & ~bus.we_i;
   assign ctrl_wr = bus.req_i & bus.we_i & (offset == RX_CTRL_ADDR);
   assign pop_ok  = rd_req & (offset == RX_DATA_ADDR) & ~empty;
   assign flush   = ctrl_wr & bus.wdata_i[CTRL_FLUSH];
   assign clr_ovf = ctrl_wr & bus.wdata_i[CTRL_CLR_OVF];
   // A byte is lost only when nothing makes room for it; a flush discards it silently.
   assign ovf_set = bus.rx_valid_i & full & ~pop_ok & ~flush;
   assign count8  = 8'(count);

   assign unused_bits = ^{bus.addr_i[31:8], bus.wdata_i[31:3]};

   console_rx_fifo #(.Depth(Depth)) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .push    (bus.rx_valid_i),
      .pop     (pop_ok),
      .flush   (flush),
      .wr_data (bus.rx_data_i),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   always_comb begin
      rd_mux = '0;
      case (offset)
         RX_DATA_ADDR:   rd_mux = rx_data_word(~empty, empty ? 8'h00 : head);
         RX_STATUS_ADDR: begin
            rd_mux[ST_NOT_EMPTY]       = ~empty;
            rd_mux[ST_FULL]            = full;
            rd_mux[ST_OVERFLOW]        = overflow;
            rd_mux[ST_COUNT_LSB +: 8]  = count8;
         end
         RX_CTRL_ADDR:   rd_mux[CTRL_IRQ_EN] = irq_en;
         default:        rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         bus.rdata_o  <= '0;
         bus.rvalid_o <= 1'b0;
         irq_o        <= 1'b0;
         overflow     <= 1'b0;
         irq_en       <= IrqDefaultEn;
      end else begin
         bus.rvalid_o <= rd_req;
         if (rd_req) bus.rdata_o <= rd_mux;
         if (ctrl_wr) irq_en <= bus.wdata_i[CTRL_IRQ_EN];
         if (ovf_set) overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
         irq_o <= irq_en & (~empty | overflow);
      end
   end

endmodule

// File: tb/tb_console_rx.sv
// Bench for console_rx: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based model of the device.
module tb_console_rx;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  logic irq;
  logic [31:0] got;
  int n_assert;
  int n_fail;

  logic [7:0]  m_q[$];
  logic        m_ovf;
  logic        m_irq_en;
  logic [31:0] m_rdata;

  console_rx_if bus ();

  console_rx #(.Depth(DEPTH), .IrqDefaultEn(1'b0)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave),
    .irq_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus/host cycle: drive, advance the model, clock, compare all outputs.
  task automatic cycle(input logic req, input logic we, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic rxv, input logic [7:0] rxd,
                       output logic [31:0] g);
    logic [31:0] hi;
    logic [31:0] exp_rd;
    logic rd, ctrl, flush, exp_rvalid, exp_irq, ovf_new;
    int sz;
    hi = $urandom();
    bus.req_i = req;
    bus.we_i = we;
    bus.addr_i = {hi[31:8], addr};
    bus.wdata_i = wdata;
    bus.rx_valid_i = rxv;
    bus.rx_data_i = rxd;

    sz = m_q.size();
    rd = req & ~we;
    ctrl = req & we & (addr == 8'h0C);
    flush = ctrl & wdata[2];
    ovf_new = 1'b0;
    exp_rd = 32'h0;
    if (rd) begin
      if (addr == 8'h00 && sz > 0) exp_rd = {1'b1, 23'b0, m_q[0]};
      else if (addr == 8'h04) exp_rd = {16'b0, sz[7:0], 5'b0, m_ovf, sz == DEPTH, sz != 0};
      else if (addr == 8'h0C) exp_rd = {31'b0, m_irq_en};
    end
    exp_irq = m_irq_en & ((sz != 0) | m_ovf);
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_irq_en = 1'b0;
      m_rdata = 32'h0;
      exp_rvalid = 1'b0;
      exp_irq = 1'b0;
    end else begin
      exp_rvalid = rd;
      if (rd) m_rdata = exp_rd;
      if (rd && addr == 8'h00 && sz > 0) void'(m_q.pop_front());
      if (flush) m_q.delete();
      if (rxv && !flush) begin
        if (m_q.size() < DEPTH) m_q.push_back(rxd);
        else ovf_new = 1'b1;
      end
      if (ovf_new) m_ovf = 1'b1;
      else if (ctrl && wdata[1]) m_ovf = 1'b0;
      if (ctrl) m_irq_en = wdata[0];
    end

    @(posedge clk);
    #1;
    chk("rvalid", {31'b0, bus.rvalid_o}, {31'b0, exp_rvalid});
    chk("rdata", bus.rdata_o, m_rdata);
    chk("irq", {31'b0, irq}, {31'b0, exp_irq});
    g = bus.rdata_o;
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] g);
    cycle(1'b1, 1'b0, a, 32'h0, 1'b0, 8'h00, g);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] g;
    cycle(1'b1, 1'b1, a, d, 1'b0, 8'h00, g);
  endtask

  task automatic push(input logic [7:0] b);
    logic [31:0] g;
    cycle(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, b, g);
  endtask

  task automatic idle();
    logic [31:0] g;
    cycle(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, g);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    m_ovf = 1'b0;
    m_irq_en = 1'b0;
    m_rdata = 32'h0;
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
    bus.addr_i = 32'h0;
    bus.wdata_i = 32'h0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i = 8'h00;
    rst_n = 1'b0;
    idle();
    idle();
    chk("reset_rdata", bus.rdata_o, 32'h0);
    rst_n = 1'b1;

    // Basic push then pop
    push(8'h41);
    push(8'h42);
    rd(8'h00, got); chk("pop_41", got, 32'h8000_0041);
    rd(8'h00, got); chk("pop_42", got, 32'h8000_0042);
    rd(8'h00, got); chk("pop_empty", got, 32'h0);
    rd(8'h04, got); chk("status_empty", got, 32'h0);

    // Fill, overflow, clear, simultaneous push/pop when full
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    rd(8'h04, got); chk("status_full", got, 32'h0000_1003);
    push(8'hAA);
    rd(8'h04, got); chk("status_ovf", got, 32'h0000_1007);
    rd(8'h00, got); chk("pop_first", got, 32'h8000_0000);
    wr(8'h0C, 32'h2);
    push(8'h10);
    cycle(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 8'h55, got);
    chk("pop_push_full", got, 32'h8000_0001);
    rd(8'h04, got); chk("status_pp_full", got, 32'h0000_1003);
    for (int i = 0; i < DEPTH; i++) rd(8'h00, got);
    chk("pop16_55", got, 32'h8000_0055);
    rd(8'h04, got); chk("status_drained", got, 32'h0);

    // Interrupt behaviour
    wr(8'h0C, 32'h1);
    idle();
    idle();
    chk("irq_empty", {31'b0, irq}, 32'h0);
    rd(8'h0C, got); chk("ctrl_read", got, 32'h1);
    push(8'h30);
    chk("irq_push_1cyc", {31'b0, irq}, 32'h0);
    idle();
    chk("irq_push_2cyc", {31'b0, irq}, 32'h1);
    rd(8'h00, got); chk("pop_30", got, 32'h8000_0030);
    idle();
    chk("irq_after_pop", {31'b0, irq}, 32'h0);
    for (int i = 0; i <= DEPTH; i++) push(8'($urandom_range(0, 255)));
    for (int i = 0; i < DEPTH; i++) rd(8'h00, got);
    idle();
    chk("irq_ovf_sticky", {31'b0, irq}, 32'h1);
    wr(8'h0C, 32'h3);
    idle();
    idle();
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    wr(8'h0C, 32'h0);

    // Flush with a concurrent push
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    cycle(1'b1, 1'b1, 8'h0C, 32'h4, 1'b1, 8'h77, got);
    rd(8'h04, got); chk("status_flush", got, 32'h0);

    // Reset during and after a read
    for (int i = 0; i < 3; i++) push(8'(8'h70 + i));
    rd(8'h04, got); chk("status_pre_rst", got, 32'h0000_0301);
    rst_n = 1'b0;
    idle();
    chk("rst_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    rst_n = 1'b1;
    rd(8'h04, got); chk("status_post_rst", got, 32'h0);
    push(8'h11);
    rst_n = 1'b0;
    rd(8'h00, got);
    chk("inflight_cancel", {31'b0, bus.rvalid_o}, 32'h0);
    rst_n = 1'b1;
    rd(8'h00, got); chk("pop_after_rst", got, 32'h0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic req, we, rxv;
      logic [7:0] a;
      logic [31:0] d;
      int sel;
      req = ($urandom_range(0, 99) < 60);
      we = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 5) a = 8'h00;
      else if (sel < 7) a = 8'h04;
      else if (sel == 7) a = 8'h0C;
      else if (sel == 8) a = 8'h08;
      else a = 8'($urandom_range(0, 255));
      d = $urandom();
      d[2] = ($urandom_range(0, 7) == 0);
      rxv = ($urandom_range(0, 99) < (((i / 100) % 2 == 0) ? 60 : 15));
      rst_n = ($urandom_range(0, 299) != 0);
      cycle(req, we, a, d, rxv, 8'($urandom_range(0, 255)), got);
    end
    rst_n = 1'b1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
